serial_adder_ctrl: RTL
======================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial WIDTH-bit adder: sequences one fulladder instance over WIDTH clock cycles.
//  Holds operands in shift registers and the ripple carry in a flop, LSB first.
//  Start/busy/done handshake towards the requester; result held until the next completion.
//  Area-cheap alternative to a WIDTH-bit ripple adder for slow datapaths.
// PARAMETERS
//  WIDTH  default 8  operand/result width in bits, legal range 1..32
// PORTS
//  clk      in   1      single clock, all state updates on rising edge
//  rst_n    in   1      reset, asynchronous assert, active-low
//  start    in   1      request; sampled only in IDLE
//  a_in     in   WIDTH  operand A, captured on the accepted start edge
//  b_in     in   WIDTH  operand B, captured on the accepted start edge
//  cin      in   1      carry-in, captured on the accepted start edge
//  busy     out  1      high while an operation is in progress (RUN and DONE)
//  done     out  1      one-cycle pulse: sum_out/cout valid from this cycle
//  sum_out  out  WIDTH  registered sum, held until the next done
//  cout     out  1      registered carry-out, held until the next done
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy=0, done=0, sum_out=0, cout=0.
//    Shift regs, carry flop and counter are cleared.
//  FSM states: IDLE, RUN, DONE (registered, one-hot or binary per package).
//  IDLE: start=1 at an edge -> a_sr<=a_in, b_sr<=b_in, c_q<=cin, s_sr<=0, cnt<=0; go RUN.
//    start=0 -> stay IDLE.
//  RUN, each edge:
//    - fulladder inputs a_sr[0], b_sr[0], c_q.
//    - s_sr <= {fa_sum, s_sr[WIDTH-1:1]}.
//    - a_sr, b_sr shift right with zero fill.
//    - c_q <= fa_carry; cnt <= cnt+1.
//    - On the edge where cnt==WIDTH-1: sum_out <= {fa_sum, s_sr[WIDTH-1:1]}, cout <= fa_carry; go DONE.
//  DONE: done=1 and busy=1 for exactly this cycle; next edge -> IDLE unconditionally.
//  Latency: start accepted at edge E -> done high in the cycle after edge E+WIDTH.
//    Minimum start-to-start spacing WIDTH+2 cycles.
//  busy = (state!=IDLE), decoded from registered state; done = (state==DONE). No combinational path from inputs to outputs.
//  start while busy (RUN or DONE) is ignored, not queued; a_in/b_in/cin may change freely then.
//  Arithmetic: {cout,sum_out} == a_in + b_in + cin, modulo 2^(WIDTH+1); unsigned, no overflow flag.
//  WIDTH=1: RUN lasts one cycle; cnt compare uses cnt==0.
//  Reset mid-RUN/DONE: abort immediately; no done pulse; outputs return to 0.
//  cnt width $clog2(WIDTH+1); it never wraps because the FSM leaves RUN at WIDTH-1.
// STRUCTURE
//  Package serial_ctrl_pkg:
//    - state encoding localparams S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10.
//    - STATE_W=2.
//  One sub-module: existing fulladder (a,b,cin,sum,carry), instantiated once as u_fa.
//  Everything else stays in this file:
//    - FSM always block.
//    - datapath regs.
//    - output regs.
// TESTING (WIDTH=8 unless noted; check done exactly 9 edges after start edge)
//  1. a=0x00 b=0x00 cin=0 -> sum_out=0x00 cout=0.
//     busy high for 9 cycles; done high for 1 cycle.
//  2. a=0xFF b=0x01 cin=0 -> sum_out=0x00 cout=1 (full carry ripple).
//     a=0xFF b=0xFF cin=1 -> sum_out=0xFF cout=1.
//  3. a=0x5A b=0x33 cin=0 -> sum_out=0x8D cout=0.
//     Then start held high through busy with a_in=0x11 changing -> no second capture.
//     Result stays 0x8D until the next accepted start.
//  4. rst_n pulsed low at cycle 4 of RUN -> busy=0 and sum_out=0 immediately.
//     No done pulse afterwards; a fresh start then completes normally.
//  5. Back-to-back: start re-asserted in the DONE cycle is ignored; asserted in the following IDLE cycle it is accepted.
//     Random 1000 ops vs a+b+cin reference model.
//  6. WIDTH=1: exhaustive 8 (a,b,cin) combos -> {cout,sum_out} matches the full-adder truth table.
//     done 2 edges after start.

Source files
------------

// File: rtl/serial_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
package serial_ctrl_pkg;

    localparam int STATE_W = 2;

    // Binary state encoding; busy/done are decoded from these.
    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder, the only arithmetic cell of the serial adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder reused over WIDTH cycles, LSB first,
// with a start/busy/done handshake and a result held until the next completion.
module serial_adder_ctrl
    import serial_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic             c_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] s_next;
    logic             accept;
    logic             finish;

    fulladder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .cin   (c_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB; the shift form also covers WIDTH=1.
    assign s_next = WIDTH'({fa_sum, s_sr} >> 1);
    assign accept = (state == S_IDLE) && start;
    assign finish = (state == S_RUN) && (cnt == LAST);

    // Control FSM; busy/done are registered alongside the state they decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (cnt == LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Operand/sum shift registers, ripple carry and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr <= '0;
            b_sr <= '0;
            s_sr <= '0;
            c_q  <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            a_sr <= a_in;
            b_sr <= b_in;
            s_sr <= '0;
            c_q  <= cin;
            cnt  <= '0;
        end else if (state == S_RUN) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            s_sr <= s_next;
            c_q  <= fa_carry;
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Result registers, loaded only on the final RUN edge and held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out <= '0;
            cout    <= 1'b0;
        end else if (finish) begin
            sum_out <= s_next;
            cout    <= fa_carry;
        end
    end

endmodule
